// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart
// mtimecmp/msip, and a valid/ready register port with a registered response.
// Each 64-bit msip doubleword holds hart 2k in bit 0 and hart 2k+1 in bit 32.
// DATA_WD is fixed at 64; ADDR_WD must be wider than 16.
module clint_mh #(
  parameter int unsigned NUM_HARTS = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned ADDR_WD   = 64,
  parameter int unsigned DATA_WD   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_en,
  output logic                 addr_hit,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [ADDR_WD-1:0]   req_addr,
  input  logic [7:0]           req_wstrb,
  input  logic [DATA_WD-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WD-1:0]   rsp_rdata,
  output logic                 rsp_err,
  input  logic [NUM_HARTS-1:0] mie_i,
  input  logic [NUM_HARTS-1:0] mtie_i,
  input  logic [NUM_HARTS-1:0] msie_i,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [NUM_HARTS-1:0] int_t_o,
  output logic [NUM_HARTS-1:0] int_s_o
);

  localparam int unsigned       PS_W     = 16;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [12:0]       DW_CMP   = 13'h0800;  // 0x4000 >> 3
  localparam logic [12:0]       DW_MTIME = 13'h17FF;  // 0xBFF8 >> 3
  localparam logic [ADDR_WD:0]  WIN_LO   = (ADDR_WD+1)'(BASE_ADDR);
  localparam logic [ADDR_WD:0]  WIN_HI   = WIN_LO + (ADDR_WD+1)'(32'h0001_0000);

  logic [63:0]          mtime;
  logic [PS_W-1:0]      presc;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic [NUM_HARTS-1:0] mtip;

  logic [ADDR_WD-1:0]   off;
  logic [12:0]          dw;
  logic                 unused_off;
  logic                 acc;
  logic                 acc_wr;
  logic [NUM_HARTS-1:0] sel_msip;
  logic [NUM_HARTS-1:0] sel_cmp;
  logic                 sel_mtime;
  logic                 mapped;
  logic [63:0]          rd_val;

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] wd,
                                        input logic [7:0]  st);
    logic [63:0] res;
    res = old;
    for (int unsigned b = 0; b < 8; b++) begin
      if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  // Window decode; the extra top bit keeps BASE_ADDR+64K from overflowing.
  assign addr_hit  = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
  assign req_ready = addr_hit & (~rsp_valid | rsp_ready);
  assign acc       = req_valid & req_ready;
  assign acc_wr    = acc & req_wen;

  assign off        = req_addr - WIN_LO[ADDR_WD-1:0];
  assign dw         = off[15:3];
  assign unused_off = ^{off[ADDR_WD-1:16], off[2:0]};

  // Register select and read mux, using pre-edge register values.
  always_comb begin
    sel_msip  = '0;
    sel_cmp   = '0;
    sel_mtime = 1'b0;
    rd_val    = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (dw == 13'(h / 2)) begin
        sel_msip[h] = 1'b1;
        if ((h % 2) == 1) rd_val[32] = msip[h];
        else              rd_val[0]  = msip[h];
      end
      if (dw == DW_CMP + 13'(h)) begin
        sel_cmp[h] = 1'b1;
        rd_val     = mtimecmp[h];
      end
    end
    if (dw == DW_MTIME) begin
      sel_mtime = 1'b1;
      rd_val    = mtime;
    end
  end

  assign mapped = (|sel_msip) | (|sel_cmp) | sel_mtime;

  // mtime and prescaler; a software write wins over a same-edge tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime <= '0;
      presc <= '0;
    end else if (acc_wr && sel_mtime) begin
      mtime <= merge(mtime, req_wdata, req_wstrb);
      presc <= '0;
    end else if (tick_en) begin
      if (presc == PS_LAST) begin
        presc <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        presc <= presc + PS_W'(1);
      end
    end
  end

  // Per-hart mtimecmp with byte-merged writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (acc_wr && sel_cmp[h]) mtimecmp[h] <= merge(mtimecmp[h], req_wdata, req_wstrb);
      end
    end
  end

  // Per-hart msip bit; odd harts live in the upper word lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (acc_wr && sel_msip[h]) begin
          if ((h % 2) == 1) begin
            if (req_wstrb[4]) msip[h] <= req_wdata[32];
          end else if (req_wstrb[0]) begin
            msip[h] <= req_wdata[0];
          end
        end
      end
    end
  end

  // Registered timer pending from current mtime/mtimecmp (one-cycle lag).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtip <= '0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
    end
  end

  // Response register: loaded on accept, held until consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_wen ? '0 : rd_val;
      rsp_err   <= ~mapped;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign mtip_o  = mtip;
  assign msip_o  = msip;
  assign int_t_o = mie_i & mtie_i & mtip;
  assign int_s_o = mie_i & msie_i & msip;

endmodule

// File: tb/tb_clint_mh.sv
// Bench for clint_mh: two instances (PRESCALE 1 and 4) share one stimulus
// stream and are checked every cycle against a register-map level model.
module tb_clint_mh;
  localparam int unsigned NH   = 2;
  localparam logic [63:0] BASE = 64'h0200_0000;

  logic clk = 1'b0;
  logic reset;
  logic tick_en, req_valid, req_wen, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [NH-1:0] mie_i, mtie_i, msie_i;

  logic [1:0]          addr_hit, req_ready, rsp_valid, rsp_err;
  logic [1:0][63:0]    rsp_rdata;
  logic [1:0][NH-1:0]  mtip_o, msip_o, int_t_o, int_s_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [63:0]   m_mtime [2];
  int unsigned   m_presc [2];
  logic [63:0]   m_cmp   [NH];
  logic [NH-1:0] m_msip;
  logic [NH-1:0] m_mtip  [2];
  logic          m_rv, m_err, m_acc;
  logic [63:0]   m_rdata [2];

  clint_mh #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .PRESCALE(1), .ADDR_WD(64), .DATA_WD(64)) dut0 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .addr_hit(addr_hit[0]),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_wen(req_wen), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .mie_i(mie_i), .mtie_i(mtie_i), .msie_i(msie_i),
    .mtip_o(mtip_o[0]), .msip_o(msip_o[0]), .int_t_o(int_t_o[0]), .int_s_o(int_s_o[0]));

  clint_mh #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .PRESCALE(4), .ADDR_WD(64), .DATA_WD(64)) dut4 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .addr_hit(addr_hit[1]),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_wen(req_wen), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .mie_i(mie_i), .mtie_i(mtie_i), .msie_i(msie_i),
    .mtip_o(mtip_o[1]), .msip_o(msip_o[1]), .int_t_o(int_t_o[1]), .int_s_o(int_s_o[1]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ps_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic model_hit(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'h1_0000);
  endfunction

  // 0 = unmapped, 1 = msip pair (idx = even hart), 2 = mtimecmp[idx], 3 = mtime
  function automatic int kind_of(input logic [63:0] a, output int idx);
    logic [63:0] off;
    int unsigned o;
    off = a - BASE;
    o   = int'(off[15:0]) & 32'hFFF8;
    idx = 0;
    if (o < 32'h4000) begin
      idx = int'(o / 8) * 2;
      return (idx < NH) ? 1 : 0;
    end
    if (o == 32'hBFF8) return 3;
    if (o >= 32'h4000 && (o - 32'h4000) / 8 < NH) begin
      idx = int'((o - 32'h4000) / 8);
      return 2;
    end
    return 0;
  endfunction

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (s[b]) m = m | (64'hFF << (8 * b));
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mtime[i] = '0; m_presc[i] = 0; m_mtip[i] = '0; m_rdata[i] = '0;
    end
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    m_msip = '0; m_rv = 1'b0; m_err = 1'b0; m_acc = 1'b0;
  endtask

  // One clock: compare all outputs at the negedge, then advance the model at the posedge.
  task automatic cycle();
    logic hit, rdy;
    int k, idx;
    logic [63:0] mask, rv [2];
    logic [NH-1:0] nt [2];
    @(negedge clk);
    hit = model_hit(req_addr);
    rdy = hit && (!m_rv || rsp_ready);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("addr_hit%0d", i), 64'(addr_hit[i]), 64'(hit));
      check($sformatf("req_ready%0d", i), 64'(req_ready[i]), 64'(rdy));
      check($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]), 64'(m_rv));
      if (m_rv) begin
        check($sformatf("rsp_rdata%0d", i), rsp_rdata[i], m_rdata[i]);
        check($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(m_err));
      end
      check($sformatf("mtip%0d", i), 64'(mtip_o[i]), 64'(m_mtip[i]));
      check($sformatf("msip%0d", i), 64'(msip_o[i]), 64'(m_msip));
      check($sformatf("int_t%0d", i), 64'(int_t_o[i]), 64'(mie_i & mtie_i & m_mtip[i]));
      check($sformatf("int_s%0d", i), 64'(int_s_o[i]), 64'(mie_i & msie_i & m_msip));
    end
    m_acc = req_valid && rdy;
    @(posedge clk);
    k = kind_of(req_addr, idx);
    for (int i = 0; i < 2; i++) begin
      for (int h = 0; h < NH; h++) nt[i][h] = (m_mtime[i] >= m_cmp[h]);
      case (k)
        1: rv[i] = {31'b0, (idx + 1 < NH) ? m_msip[idx+1] : 1'b0, 31'b0, m_msip[idx]};
        2: rv[i] = m_cmp[idx];
        3: rv[i] = m_mtime[i];
        default: rv[i] = '0;
      endcase
    end
    if (m_acc) begin
      m_rv = 1'b1;
      m_err = (k == 0);
      for (int i = 0; i < 2; i++) m_rdata[i] = req_wen ? 64'h0 : rv[i];
    end else if (rsp_ready) begin
      m_rv = 1'b0;
    end
    mask = strb_mask(req_wstrb);
    for (int i = 0; i < 2; i++) begin
      if (m_acc && req_wen && k == 3) begin
        m_mtime[i] = (m_mtime[i] & ~mask) | (req_wdata & mask);
        m_presc[i] = 0;
      end else if (tick_en) begin
        m_presc[i]++;
        if (m_presc[i] == ps_of(i)) begin
          m_presc[i] = 0;
          m_mtime[i] = m_mtime[i] + 1;
        end
      end
      m_mtip[i] = nt[i];
    end
    if (m_acc && req_wen && k == 2) m_cmp[idx] = (m_cmp[idx] & ~mask) | (req_wdata & mask);
    if (m_acc && req_wen && k == 1) begin
      if (req_wstrb[0]) m_msip[idx] = req_wdata[0];
      if (idx + 1 < NH && req_wstrb[4]) m_msip[idx+1] = req_wdata[32];
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_rsp_valid%0d", i), 64'(rsp_valid[i]), 64'h0);
      check($sformatf("rst_rsp_err%0d", i), 64'(rsp_err[i]), 64'h0);
      check($sformatf("rst_rsp_rdata%0d", i), rsp_rdata[i], 64'h0);
      check($sformatf("rst_mtip%0d", i), 64'(mtip_o[i]), 64'h0);
      check($sformatf("rst_msip%0d", i), 64'(msip_o[i]), 64'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic bus_op(input logic wen, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s);
    int n;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 20);
    if (!m_acc) check("accept_timeout", 64'h0, 64'h1);
    req_valid = 1'b0;
  endtask

  function automatic logic [63:0] pick_addr();
    logic [63:0] a;
    case ($urandom_range(0, 10))
      0: a = BASE;
      1: a = BASE + 64'h8;
      2: a = BASE + 64'h4000;
      3: a = BASE + 64'h4008;
      4: a = BASE + 64'h4010;
      5, 6: a = BASE + 64'hBFF8;
      7: a = BASE + 64'h8000;
      8: a = BASE + 64'hFFF8;
      9: a = BASE - 64'h8;
      default: a = BASE + 64'h1_0000;
    endcase
    if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    reset = 1'b0; tick_en = 1'b1; req_valid = 1'b0; req_wen = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mie_i = 2'b11; mtie_i = 2'b01; msie_i = 2'b00;
    do_reset();

    // timer interrupt on hart 0
    bus_op(1'b1, BASE + 64'h4000, 64'd5, 8'hFF);
    repeat (10) cycle();
    check("p1_mtip0", 64'(mtip_o[0][0]), 64'h1);
    check("p1_int_t0", 64'(int_t_o[0][0]), 64'h1);
    check("p1_mtip1", 64'(mtip_o[0][1]), 64'h0);
    mtie_i = 2'b00;
    #1;
    check("p1_int_t0_masked", 64'(int_t_o[0][0]), 64'h0);
    mtie_i = 2'b11;

    // tick_en pause
    tick_en = 1'b0;
    repeat (10) cycle();
    bus_op(1'b0, BASE + 64'hBFF8, 64'h0, 8'h00);
    tick_en = 1'b1;
    repeat (9) cycle();
    bus_op(1'b0, BASE + 64'hBFF8, 64'h0, 8'h00);

    // wrap, and write-wins over tick
    bus_op(1'b1, BASE + 64'h4008, 64'h0, 8'hFF);
    bus_op(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    cycle();
    bus_op(1'b0, BASE + 64'hBFF8, 64'h0, 8'h00);
    check("wrap_ffff", rsp_rdata[0], 64'hFFFF_FFFF_FFFF_FFFF);
    bus_op(1'b0, BASE + 64'hBFF8, 64'h0, 8'h00);
    check("wrap_zero", rsp_rdata[0], 64'h0);
    repeat (3) cycle();
    check("cmp0_mtip1", 64'(mtip_o[0][1]), 64'h1);
    bus_op(1'b1, BASE + 64'hBFF8, 64'h1234, 8'hFF);
    bus_op(1'b0, BASE + 64'hBFF8, 64'h0, 8'h00);
    check("wr_wins_ps1", rsp_rdata[0], 64'h1234);
    check("wr_wins_ps4", rsp_rdata[1], 64'h1234);

    // software interrupt on hart 1
    bus_op(1'b1, BASE, 64'h1_0000_0000, 8'hF0);
    check("msip1_set", 64'(msip_o[0]), 64'h2);
    msie_i = 2'b10;
    #1;
    check("int_s1_on", 64'(int_s_o[0][1]), 64'h1);
    msie_i = 2'b00;
    #1;
    check("int_s1_off", 64'(int_s_o[0][1]), 64'h0);
    bus_op(1'b1, BASE, 64'h0, 8'hF0);
    check("msip1_clr", 64'(msip_o[0][1]), 64'h0);

    // unmapped offsets
    bus_op(1'b0, BASE + 64'h4000 + 64'(8 * NH), 64'h0, 8'h00);
    check("unm_cmp_rdata", rsp_rdata[0], 64'h0);
    check("unm_cmp_err", 64'(rsp_err[0]), 64'h1);
    bus_op(1'b0, BASE + 64'h8000, 64'h0, 8'h00);
    check("unm_8000_err", 64'(rsp_err[0]), 64'h1);
    bus_op(1'b1, BASE + 64'h8000, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    check("unm_wr_err", 64'(rsp_err[0]), 64'h1);
    repeat (2) cycle();

    // backpressure and reset during a held response
    rsp_ready = 1'b0;
    bus_op(1'b0, BASE + 64'h4000, 64'h0, 8'h00);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'hBFF8;
    repeat (3) cycle();
    check("hold_ready", 64'(req_ready[0]), 64'h0);
    check("hold_rdata", rsp_rdata[0], 64'd5);
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 64'(req_ready[0]), 64'h1);
    cycle();
    check("release_acc", 64'(m_acc), 64'h1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    cycle();
    check("pre_rst_valid", 64'(rsp_valid[0]), 64'h1);
    do_reset();
    rsp_ready = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      tick_en   = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      mie_i     = NH'($urandom);
      mtie_i    = NH'($urandom);
      msie_i    = NH'($urandom);
      req_valid = $urandom_range(0, 1);
      req_wen   = $urandom_range(0, 1);
      req_addr  = pick_addr();
      req_wstrb = 8'($urandom);
      case ($urandom_range(0, 2))
        0: req_wdata = {$urandom, $urandom};
        1: req_wdata = m_mtime[0] + 64'($urandom_range(0, 30));
        default: req_wdata = {31'b0, 1'($urandom), 31'b0, 1'($urandom)};
      endcase
      if ($urandom_range(0, 249) == 0) do_reset();
      else cycle();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Parametrised multi-hart core-local interruptor.
- Successor to the single-hart CLINT that sits beside the EXU/MEU data path.
- Provides one shared 64-bit mtime with a programmable prescaler, per-hart mtimecmp and msip registers, and a valid/ready register port with a registered response.
- Per-hart timer and software interrupt outputs are gated by the hart's mie/mtie/msie CSR bits.

Parameters:
- NUM_HARTS, 2, number of harts (1..8).
- BASE_ADDR, 64'h0200_0000, window base; window size is 64 KiB.
- PRESCALE, 1, core cycles per mtime tick (1..65535).
- ADDR_WD, 64, request address width.
- DATA_WD, 64, data width (fixed at 64).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tick_en  in  1  1 = mtime counts; 0 = frozen (debug halt)
- addr_hit  out  1  combinational; req_addr falls in [BASE_ADDR, BASE_ADDR+64K)
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WD  byte address
- req_wstrb  in  8  byte write strobes
- req_wdata  in  DATA_WD  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WD  read data (0 for writes)
- rsp_err  out  1  unmapped offset inside the window
- mie_i  in  NUM_HARTS  per-hart mstatus.MIE
- mtie_i  in  NUM_HARTS  per-hart mie.MTIE
- msie_i  in  NUM_HARTS  per-hart mie.MSIE
- mtip_o  out  NUM_HARTS  raw timer pending
- msip_o  out  NUM_HARTS  raw software pending
- int_t_o  out  NUM_HARTS  mie_i & mtie_i & mtip_o
- int_s_o  out  NUM_HARTS  mie_i & msie_i & msip_o

Behaviour:
Register map (offset from BASE_ADDR):
- msip[h] at 0x0000+4h: bit0 only, other bits read 0; reachable via 64-bit access with strobes 3:0 or 7:4 as appropriate.
- mtimecmp[h] at 0x4000+8h: 64-bit.
- mtime at 0xBFF8: 64-bit.
- Offsets for h >= NUM_HARTS, and all other offsets, are unmapped: reads return 0, writes are dropped, rsp_err=1.
- Address decode uses req_addr[15:0] with bits [2:0] ignored for the 64-bit registers.

Reset (reset=0), asynchronous:
- mtime=0, prescaler=0, msip=0, mtimecmp=all ones.
- mtip_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transaction discards any pending response.

Handshake:
- req_ready = addr_hit & (~rsp_valid | rsp_ready).
- Non-hit requests are never accepted; the top level routes them to SRAM.
- Accept at edge N gives rsp_valid=1 after edge N (1-cycle latency).
- rsp_valid holds with stable rdata/err until rsp_ready.
- Back-to-back accepts are allowed when rsp_ready=1 (full throughput).

Reads:
- Return the register value before edge N; any same-edge tick or write is not visible.

Writes:
- Byte-merge under req_wstrb and take effect at edge N.

mtime:
- Prescaler counts 0..PRESCALE-1 while tick_en=1.
- mtime increments when prescaler==PRESCALE-1; the prescaler then wraps to 0.
- tick_en=0 holds both counters.
- mtime wraps 2^64-1 -> 0.
- mtime write and tick on the same edge: the write wins and the prescaler clears to 0.
- PRESCALE=1: mtime increments every enabled cycle.

mtip:
- mtip_o[h] is a registered (mtime >= mtimecmp[h]) using current register values, so it lags any mtime/mtimecmp change by 1 cycle.
- Comparison is unsigned.

Outputs:
- msip_o mirrors the msip bit directly from the register.
- int_t_o and int_s_o are combinational gates on registered pending bits.

Test Plan:
- Reset release, PRESCALE=1, tick_en=1, write mtimecmp[0]=5 at cycle 1 -> mtip_o[0] rises 1 cycle after mtime reads 5; int_t_o[0]=1 only with mie_i[0]=mtie_i[0]=1; mtip_o[1]=0 (cmp all ones).
- PRESCALE=4, tick_en toggled 0 for 10 cycles -> mtime advances once per 4 enabled cycles; frozen value holds across the pause.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFE, then run -> reads …FFFF then 0; mtip_o for mtimecmp=0 stays 1; a same-edge mtime write during a tick loads the written value exactly.
- Write msip[1] with wstrb=8'hF0, wdata=64'h1_0000_0000 (offset 0x0000) -> msip_o[1]=1; int_s_o[1] follows msie_i[1]; write 0 clears it.
- Read 0x4000+8*NUM_HARTS and 0x8000 -> rsp_rdata=0, rsp_err=1; write there changes nothing.
- Hold rsp_ready=0 with req_valid=1 -> req_ready=0, response stable; raise rsp_ready -> next request accepted the same cycle; assert reset mid-hold -> rsp_valid=0 immediately.
